// File: rtl/alarm_beep_generator.sv
// Alarm beep pattern generator: a start tick launches BEEPS on/off pairs timed in en_tick strobes.
// Reports busy while the pattern runs and a one-cycle done tick on normal completion.
module alarm_beep_generator #(
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 4,
    parameter int BEEPS     = 3,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en_tick,
    input  logic start,
    input  logic stop,
    output logic level,
    output logic busy,
    output logic done
);

    localparam int BW = $clog2(BEEPS + 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_TICKS - 1);
    localparam logic [BW-1:0]    BEEP_LAST  = BW'(BEEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  phase_reg;
    logic [BW-1:0]     beep_reg;
    logic              level_reg;
    logic              busy_reg;
    logic              done_reg;

    // Outputs are flops updated together with the state, so level/busy always track it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            phase_reg <= '0;
            beep_reg  <= '0;
            level_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !stop) begin
                        state_reg <= ON;
                        phase_reg <= '0;
                        beep_reg  <= '0;
                        level_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                ON: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        phase_reg <= '0;
                        beep_reg  <= '0;
                        level_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else if (en_tick) begin
                        if (phase_reg == ON_LAST) begin
                            state_reg <= OFF;
                            phase_reg <= '0;
                            beep_reg  <= beep_reg + BW'(1);
                            level_reg <= 1'b0;
                        end else begin
                            phase_reg <= phase_reg + CNT_W'(1);
                        end
                    end
                end
                OFF: begin
                    // Abort has priority over a same-cycle phase expiry.
                    if (stop) begin
                        state_reg <= IDLE;
                        phase_reg <= '0;
                        beep_reg  <= '0;
                        level_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else if (en_tick) begin
                        if (phase_reg == OFF_LAST) begin
                            phase_reg <= '0;
                            if (beep_reg == BEEP_LAST) begin
                                state_reg <= IDLE;
                                beep_reg  <= '0;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg <= ON;
                                level_reg <= 1'b1;
                            end
                        end else begin
                            phase_reg <= phase_reg + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    phase_reg <= '0;
                    beep_reg  <= '0;
                    level_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign level = level_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_alarm_beep_generator.sv
// Bench for alarm_beep_generator: directed scenarios plus random traffic, checked every cycle
// against a tick-count model of the beep pattern.
module tb_alarm_beep_generator;

    localparam int ON_T  = 4;
    localparam int OFF_T = 4;
    localparam int NB    = 3;
    localparam int PER   = ON_T + OFF_T;
    localparam int TOTAL = NB * PER;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_tick = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic level, busy, done;

    int n_checks = 0;
    int n_pass = 0;

    // Model: pattern is active, t counts en_tick strobes since it began.
    bit m_active = 1'b0;
    int m_t = 0;
    bit m_done = 1'b0;

    alarm_beep_generator #(
        .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .BEEPS(NB), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .en_tick(en_tick), .start(start), .stop(stop),
        .level(level), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Compare on the falling edge, then advance the model with the inputs the next rising edge samples.
    always @(negedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_t = 0;
            m_done = 1'b0;
        end else begin
            check("level", level, m_active && ((m_t % PER) < ON_T));
            check("busy", busy, m_active);
            check("done", done, m_done);
            m_done = 1'b0;
            if (!m_active) begin
                if (start && !stop) begin
                    m_active = 1'b1;
                    m_t = 0;
                end
            end else if (stop) begin
                m_active = 1'b0;
                m_t = 0;
            end else if (en_tick) begin
                m_t++;
                if (m_t == TOTAL) begin
                    m_active = 1'b0;
                    m_t = 0;
                    m_done = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic st, input logic sp);
        en_tick = e;
        start = st;
        stop = sp;
    endtask

    task automatic scen_basic(input bit extra_start);
        int dn = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (c == 0)  check("s1_idle_c0", busy, 1'b0);
            if (c == 1)  check("s1_lvl_c1", level, 1'b1);
            if (c == 4)  check("s1_lvl_c4", level, 1'b1);
            if (c == 5)  check("s1_lvl_c5", level, 1'b0);
            if (c == 9)  check("s1_lvl_c9", level, 1'b1);
            if (c == 20) check("s1_lvl_c20", level, 1'b1);
            if (c == 21) check("s1_lvl_c21", level, 1'b0);
            if (c == 24) check("s1_busy_c24", busy, 1'b1);
            if (c == 25) begin
                check("s1_busy_c25", busy, 1'b0);
                check("s1_done_c25", done, 1'b1);
            end
            dn += int'(done);
            drive(1'b1, (c == 0) || (extra_start && c == 10), 1'b0);
        end
        check_int("s1_done_count", dn, 1);
        $display("scenario basic extra_start=%0b done_ticks=%0d", extra_start, dn);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", level, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        step();

        scen_basic(1'b0);

        begin
            int dn = 0;
            for (int c = 0; c < 100; c++) begin
                step();
                if (c == 15) check("s2_lvl_c15", level, 1'b1);
                if (c == 16) check("s2_lvl_c16", level, 1'b0);
                if (c == 96) check("s2_done_c96", done, 1'b1);
                dn += int'(done);
                drive((c % 4) == 3, c == 0, 1'b0);
            end
            check_int("s2_done_count", dn, 1);
            $display("scenario slow_tick done_ticks=%0d", dn);
        end

        begin
            int dn_early = 0;
            for (int c = 0; c < 40; c++) begin
                step();
                if (c == 6) check("s3_busy_c6", busy, 1'b1);
                if (c == 7) begin
                    check("s3_busy_c7", busy, 1'b0);
                    check("s3_lvl_c7", level, 1'b0);
                end
                if (c == 11) check("s3_lvl_c11", level, 1'b1);
                if (c == 35) check("s3_done_c35", done, 1'b1);
                if (c < 35) dn_early += int'(done);
                drive(1'b1, (c == 0) || (c == 10), c == 6);
            end
            check_int("s3_no_done_after_abort", dn_early, 0);
            $display("scenario stop_restart early_done=%0d", dn_early);
        end

        begin
            int act = 0;
            for (int c = 0; c < 21; c++) begin
                step();
                if (c >= 1) act += int'(busy) + int'(level);
                drive(1'b1, c == 0, c == 0);
            end
            check_int("s4_start_stop_idle", act, 0);
            $display("scenario start_and_stop activity=%0d", act);
        end

        scen_basic(1'b1);

        begin
            for (int c = 0; c < 8; c++) begin
                step();
                drive(1'b1, c == 0, 1'b0);
            end
            check("s6_busy_before_rst", busy, 1'b1);
            #2;
            rst = 1'b1;
            #1;
            check("s6_async_level", level, 1'b0);
            check("s6_async_busy", busy, 1'b0);
            check("s6_async_done", done, 1'b0);
            step();
            step();
            rst = 1'b0;
            drive(1'b0, 1'b0, 1'b0);
            $display("scenario async_reset applied mid-pattern");
        end
        scen_basic(1'b0);

        begin
            int starts = 0;
            int dones = 0;
            for (int c = 0; c < 3000; c++) begin
                step();
                dones += int'(done);
                drive($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
                starts += int'(start);
            end
            $display("scenario random starts=%0d done_ticks=%0d", starts, dones);
        end

        step();
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alarm_beep_generator.md
Name: alarm_beep_generator

Overview:
- Inverse of the button edge-detect path: turns a one-cycle start tick into a timed, repeating buzzer level pattern.
- Pattern is BEEPS repetitions of ON_TICKS high then OFF_TICKS low, timed in prescaler strobes (en_tick).
- Sits between alarm-match/control logic and the buzzer/LED pin.
- Also reports busy and a one-cycle done tick when the pattern completes.

Parameters:
- ON_TICKS, 4, en_tick strobes per beep high phase (must be >=1).
- OFF_TICKS, 4, en_tick strobes per beep low phase (must be >=1).
- BEEPS, 3, number of on/off pairs per trigger (must be >=1).
- CNT_W, 8, phase counter width; 2^CNT_W must be >= max(ON_TICKS, OFF_TICKS).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en_tick  in  1  prescaler strobe, one clk wide; advances phase counter.
- start  in  1  one-cycle tick; begins pattern when idle.
- stop  in  1  one-cycle tick; aborts pattern.
- level  out  1  buzzer drive; registered.
- busy  out  1  high while pattern active (state != IDLE).
- done  out  1  one-cycle tick on normal completion; registered.

Behaviour:
- Reset (async): state=IDLE, phase counter=0, beep counter=0, level=0, busy=0, done=0. Reset mid-pattern clears everything immediately; no done is issued.
- States: IDLE, ON, OFF. level=1 only in ON. busy=1 in ON and OFF.
- IDLE:
  - start=1 and stop=0 -> ON next cycle; phase counter=0, beep counter=0.
  - Latency: start at cycle k gives level=1 at cycle k+1.
- ON:
  - Phase counter increments only on cycles with en_tick=1.
  - en_tick=1 with phase counter==ON_TICKS-1 -> OFF; phase counter=0; beep counter+1.
- OFF:
  - Phase counter increments on en_tick.
  - en_tick=1 with phase counter==OFF_TICKS-1:
    - beep counter==BEEPS -> IDLE, and done=1 for exactly the first IDLE cycle.
    - otherwise -> ON; phase counter=0.
- stop=1 in ON or OFF -> IDLE next cycle; level=0; counters cleared; done stays 0. stop overrides any same-cycle en_tick expiry.
- start while busy: ignored. No retrigger, no timing change.
- start and stop together in IDLE: stop wins; remains IDLE.
- en_tick absent: state and counters hold indefinitely.
- done and busy:
  - done is never asserted while busy=1.
  - done=1 coincides with busy falling to 0.
  - done=0 otherwise, including after an abort.
- Counter rules:
  - Phase counter is CNT_W bits and never exceeds max(ON_TICKS, OFF_TICKS)-1, so no wrap.
  - Beep counter width is clog2(BEEPS+1); it saturates logically because the FSM exits at BEEPS.
- No combinational path from inputs to outputs; all outputs are flops or pure functions of state flops.

Test Plan:
- Defaults, en_tick=1 every cycle, start at cycle 0 -> level=1 on cycles 1-4, 9-12, 17-20 and 0 elsewhere; busy=1 on cycles 1-24; done=1 only at cycle 25, with busy=0 at 25.
- Defaults, en_tick high when cycle%4==3, start at cycle 0 -> first level high on cycles 1-15, OFF entered at cycle 16; total of 3 beeps, then a single done tick.
- Defaults, en_tick every cycle, start at 0, stop at cycle 6 -> level=0 and busy=0 from cycle 7; done never asserts; a new start at cycle 10 gives level=1 at cycle 11.
- start and stop both asserted at cycle 0 while IDLE -> busy and level stay 0 for 20 cycles.
- Defaults, en_tick every cycle, start at 0, extra start at cycle 10 -> waveform identical to scenario 1 (done at 25).
- rst pulsed asynchronously mid-cycle at cycle 7 of scenario 1 -> level, busy and done go 0 immediately without waiting for clk; after release, start gives a full 3-beep pattern with done 25 cycles after start.
